// File: rtl/axis_byte_packer.sv
// Packs an AXI-Stream byte stream into M_BYTES-wide words, lane 0 first.
// A word completes on its last lane or on tlast and is held in a single output register.
module axis_byte_packer #(
  parameter int M_BYTES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             s_axis_tdata,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  input  logic                   s_axis_tlast,
  output logic [8*M_BYTES-1:0]   m_axis_tdata,
  output logic [M_BYTES-1:0]     m_axis_tkeep,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic                   m_axis_tlast
);

  localparam int LANE_W = $clog2(M_BYTES);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(M_BYTES - 1);

  logic [LANE_W-1:0]    lane_p0;
  logic [8*M_BYTES-1:0] acc_p0;
  logic [8*M_BYTES-1:0] word;
  logic [M_BYTES-1:0]   keep;
  logic                 accept;
  logic                 complete;

  // Output register can take a new word whenever it is empty or being drained this cycle.
  assign s_axis_tready = !m_axis_tvalid || m_axis_tready;
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign complete      = accept && (s_axis_tlast || (lane_p0 == LAST_LANE));

  // Lanes above the current one are always zero in the accumulator, so merging is a plain overwrite.
  always_comb begin
    word = acc_p0;
    keep = '0;
    for (int i = 0; i < M_BYTES; i++) begin
      if (LANE_W'(i) == lane_p0) word[8*i +: 8] = s_axis_tdata;
      if (LANE_W'(i) <= lane_p0) keep[i] = 1'b1;
    end
  end

  // Stage boundary: accumulator/lane counter feed the output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane_p0       <= '0;
      acc_p0        <= '0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tvalid <= 1'b0;
    end else begin
      if (m_axis_tvalid && m_axis_tready) m_axis_tvalid <= 1'b0;
      if (accept) begin
        if (complete) begin
          m_axis_tdata  <= word;
          m_axis_tkeep  <= keep;
          m_axis_tlast  <= s_axis_tlast;
          m_axis_tvalid <= 1'b1;
          lane_p0       <= '0;
          acc_p0        <= '0;
        end else begin
          acc_p0  <= word;
          lane_p0 <= lane_p0 + LANE_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_axis_byte_packer.sv
// Scoreboard bench for axis_byte_packer (M_BYTES=4): byte-level packet model feeds an
// expected-word queue; an independent monitor pops and compares on each output handshake.
module tb_axis_byte_packer;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } word_t;

  logic        clk;
  logic        rst;
  logic [7:0]  s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic        s_axis_tlast;
  logic [31:0] m_axis_tdata;
  logic [3:0]  m_axis_tkeep;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;

  int    vectors = 0;
  int    errors  = 0;
  int    rdy_mode = 0;   // 0: always ready, 1: random, 2: stalled
  bit    lat_pend = 0;
  logic [7:0] chunk[$];
  word_t exp_q[$];
  word_t seen[$];

  axis_byte_packer #(.M_BYTES(4)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(negedge clk);
      case (rdy_mode)
        0:       m_axis_tready = 1'b1;
        1:       m_axis_tready = ($urandom_range(99) < 70);
        default: m_axis_tready = 1'b0;
      endcase
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: bytes gather into a packet chunk; a word is due at 4 bytes or at tlast.
  task automatic model_accept(input logic [7:0] b, input logic last);
    word_t w;
    chunk.push_back(b);
    if (chunk.size() == 4 || last) begin
      w.d = '0;
      for (int i = 0; i < chunk.size(); i++) w.d[8*i +: 8] = chunk[i];
      w.k = 4'((1 << chunk.size()) - 1);
      w.l = last;
      exp_q.push_back(w);
      chunk.delete();
      lat_pend = 1;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (lat_pend) begin
      check("latency_tvalid", 64'(m_axis_tvalid), 64'd1);
      lat_pend = 0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last, input int gap_pct);
    int  n;
    bit  rdy;
    n = 0;
    while ($urandom_range(99) < gap_pct && n < 20) begin
      tick();
      s_axis_tvalid = 1'b0;
      s_axis_tdata  = 8'($urandom);
      s_axis_tlast  = 1'($urandom_range(1));
      n++;
    end
    tick();
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = b;
    s_axis_tlast  = last;
    n = 0;
    forever begin
      #1 rdy = s_axis_tready;
      @(posedge clk);
      if (rdy) break;
      n++;
      if (n > 200) begin
        errors++;
        $display("FAIL send_timeout: got no accept after %0d cycles, expected accept", n);
        $fatal(1, "input never accepted");
      end
      tick();
    end
    model_accept(b, last);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || m_axis_tvalid) && n < 500) begin
      tick();
      s_axis_tvalid = 1'b0;
      n++;
    end
    check("drain_done", 64'(n < 500), 64'd1);
  endtask

  task automatic chk_seen(input int idx, input logic [31:0] d, input logic [3:0] k, input logic l);
    logic [63:0] act;
    act = (idx < seen.size()) ? {27'd0, seen[idx].l, seen[idx].k, seen[idx].d} : 64'hDEAD;
    check($sformatf("word%0d", idx), act, {27'd0, l, k, d});
  endtask

  // Monitor: compares every transferred word and checks stability while stalled.
  initial begin
    bit    hold;
    word_t held;
    word_t e;
    hold = 0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) hold = 0;
      if (hold) check("hold_stable", {27'd0, m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tdata},
                      {27'd0, 1'b1, held.l, held.k, held.d});
      if (m_axis_tvalid && m_axis_tready) begin
        e.d = m_axis_tdata; e.k = m_axis_tkeep; e.l = m_axis_tlast;
        seen.push_back(e);
        if (exp_q.size() == 0) begin
          check("unexpected_word", {27'd0, e.l, e.k, e.d}, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          word_t x;
          x = exp_q.pop_front();
          check("scoreboard", {27'd0, e.l, e.k, e.d}, {27'd0, x.l, x.k, x.d});
        end
      end
      hold = m_axis_tvalid && !m_axis_tready && !rst;
      held.d = m_axis_tdata; held.k = m_axis_tkeep; held.l = m_axis_tlast;
    end
  end

  initial begin
    logic [7:0] pkt[$];
    int len;
    rst = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tlast  = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_outputs", {27'd0, m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tdata}, 64'd0);
    rst = 1'b0;
    #1 check("post_rst_tready", 64'(s_axis_tready), 64'd1);

    // Two full words, continuous input
    seen.delete();
    for (int i = 1; i <= 8; i++) send_byte(8'(i), i == 8, 0);
    drain();
    chk_seen(0, 32'h04030201, 4'hF, 1'b0);
    chk_seen(1, 32'h08070605, 4'hF, 1'b1);

    // Five-byte packet leaves a one-lane tail word
    seen.delete();
    send_byte(8'hAA, 0, 0); send_byte(8'hBB, 0, 0); send_byte(8'hCC, 0, 0);
    send_byte(8'hDD, 0, 0); send_byte(8'hEE, 1, 0);
    drain();
    chk_seen(0, 32'hDDCCBBAA, 4'hF, 1'b0);
    chk_seen(1, 32'h000000EE, 4'h1, 1'b1);

    // Single-byte packet
    seen.delete();
    send_byte(8'h5A, 1, 0);
    drain();
    chk_seen(0, 32'h0000005A, 4'h1, 1'b1);

    // Stall the first word for 10 cycles with the next byte offered
    seen.delete();
    rdy_mode = 2;
    send_byte(8'h10, 0, 0); send_byte(8'h20, 0, 0);
    send_byte(8'h30, 0, 0); send_byte(8'h40, 0, 0);
    for (int i = 0; i < 10; i++) begin
      tick();
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = 8'h50;
      s_axis_tlast  = 1'b1;
      #1;
      check("stall_tready", 64'(s_axis_tready), 64'd0);
      check("stall_word", {31'd0, m_axis_tvalid, m_axis_tdata}, {31'd0, 1'b1, 32'h40302010});
    end
    rdy_mode = 0;
    send_byte(8'h50, 1, 0);
    drain();
    chk_seen(0, 32'h40302010, 4'hF, 1'b0);
    chk_seen(1, 32'h00000050, 4'h1, 1'b1);
    check("stall_count", 64'(seen.size()), 64'd2);

    // Reset in the middle of a packet discards the partial word
    seen.delete();
    send_byte(8'h77, 0, 0); send_byte(8'h88, 0, 0);
    tick();
    s_axis_tvalid = 1'b0;
    rst = 1'b1;
    chunk.delete();
    lat_pend = 0;
    #1 check("midrst_outputs", {27'd0, m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tdata}, 64'd0);
    tick();
    check("midrst_hold", {27'd0, m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tdata}, 64'd0);
    rst = 1'b0;
    send_byte(8'h11, 0, 0); send_byte(8'h22, 0, 0);
    send_byte(8'h33, 0, 0); send_byte(8'h44, 1, 0);
    drain();
    chk_seen(0, 32'h44332211, 4'hF, 1'b1);
    check("midrst_count", 64'(seen.size()), 64'd1);

    // Random packets with input gaps and output backpressure
    rdy_mode = 1;
    for (int p = 0; p < 1000; p++) begin
      len = $urandom_range(1, 9);
      for (int i = 0; i < len; i++) send_byte(8'($urandom), i == len - 1, 30);
    end
    drain();
    check("random_leftover", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/axis_byte_packer.md
AXIS_BYTE_PACKER -- requirements
Module: axis_byte_packer

Interface
REQ-001 Parameter M_BYTES, default 4: output word width in bytes; legal range 2..16.
REQ-002 clk  input  1  single clock; all logic is on the rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 s_axis_tdata  input  8  input byte stream.
REQ-005 s_axis_tvalid  input  1  input byte valid.
REQ-006 s_axis_tready  output  1  input byte accepted when high together with tvalid.
REQ-007 s_axis_tlast  input  1  marks the final byte of a packet.
REQ-008 m_axis_tdata  output  8*M_BYTES  packed word; lane 0 (bits 7:0) holds the first byte.
REQ-009 m_axis_tkeep  output  M_BYTES  one bit per lane; high marks a valid lane.
REQ-010 m_axis_tvalid  output  1  output word valid.
REQ-011 m_axis_tready  input  1  downstream ready.
REQ-012 m_axis_tlast  output  1  word contains the final byte of a packet.

Function
REQ-013 A byte is accepted in any cycle where s_axis_tvalid and s_axis_tready are both high; no other input cycle has any effect.
REQ-014 s_axis_tready SHALL equal (!m_axis_tvalid || m_axis_tready), combinationally.
REQ-015 A lane counter (width $clog2(M_BYTES)) holds the next lane index; an accepted byte is written to that lane of the accumulator.
REQ-016 Word completion occurs when the accepted byte lands in lane M_BYTES-1, or when s_axis_tlast=1.
- On completion the assembled word, keep and last are loaded into the output register on the same edge.
- On completion the lane counter returns to 0 and the accumulator is cleared.
REQ-017 tkeep SHALL be contiguous from lane 0: lanes 0..k are set, where k is the lane of the completing byte.
REQ-018 Lanes above k SHALL read as zero in m_axis_tdata.
REQ-019 m_axis_tlast SHALL equal s_axis_tlast of the completing byte.
REQ-020 Latency: m_axis_tvalid rises on the edge after the completing byte is accepted (1 cycle).
REQ-021 Throughput: one byte per cycle while m_axis_tready stays high.
REQ-022 Back-to-back words SHALL not insert bubbles, because the output register reloads on the same edge that its previous word is consumed.
REQ-023 m_axis_tvalid SHALL clear on a handshake (tvalid and tready high) unless a new word completes on that edge.
REQ-024 While m_axis_tvalid=1 and m_axis_tready=0, m_axis_tdata, m_axis_tkeep and m_axis_tlast SHALL hold stable, and no input byte is accepted.
REQ-025 A tlast byte in lane 0 SHALL produce a single word with keep=1.
- No zero-keep word is ever emitted.
REQ-026 Gaps in s_axis_tvalid SHALL not alter the lane counter or the accumulator.
REQ-027 No state machine is needed beyond the lane counter and output-valid flag; the counter wraps from M_BYTES-1 to 0 only via completion.

Reset
REQ-028 While rst is high, the following SHALL be held at zero: m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, the lane counter and the accumulator.
REQ-029 rst asserted mid-packet SHALL discard all partial and pending data.
- The first byte accepted after reset goes to lane 0.
REQ-030 After rst deasserts, s_axis_tready SHALL be 1 (output empty).

Verification (M_BYTES=4)
REQ-031 Bytes 01..08, tlast on 08, m_tready=1 -> two words:
- 0x04030201, keep=F, last=0;
- 0x08070605, keep=F, last=1;
- each word appears 1 cycle after its completing byte.
REQ-032 Packet AA,BB,CC,DD,EE, tlast on EE -> two words:
- 0xDDCCBBAA, keep=F, last=0;
- 0x000000EE, keep=1, last=1.
REQ-033 Single byte 5A with tlast -> 0x0000005A, keep=1, last=1.
REQ-034 Stall: first word completes with m_tready=0 for 10 cycles.
- s_tready stays 0 and the word stays stable throughout.
- On release, the word is consumed and input resumes with no loss or duplication.
REQ-035 Reset pulse after 2 bytes of a packet, then bytes 11,22,33,44 -> all outputs read 0 during reset, then 0x44332211, keep=F.
REQ-036 Random tvalid/tready gaps over 1000 random-length packets -> output byte stream and packet boundaries match a scoreboard model exactly.
